// File: rtl/wd_timer_servicer_if.sv
// Avalon-MM segment shared by the servicer (master) and the watchdog interval timer (slave).
// irq travels with the bus because the timer drives it alongside readdata.
interface wd_timer_servicer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/wd_timer_servicer.sv
// Watchdog timer servicer: enables the timer irq after reset, turns heartbeats into reloads,
// clears timeouts and raises a sticky board-reset request after MAX_MISSES missed heartbeats.
module wd_timer_servicer #(
    parameter int unsigned MAX_MISSES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                kick_i,
    wd_timer_servicer_if.master bus,
    output logic [3:0]          miss_count_o,
    output logic                reset_req_o,
    output logic                busy_o
);
    typedef enum logic [2:0] {
        INIT_CTL, INIT_CLR, IDLE, RD_STAT, RD_WAIT, CLR_STAT, KICK
    } state_e;

    localparam logic [3:0] MAX_M = 4'(MAX_MISSES);

    state_e      state_q, state_d;
    logic        start_q;
    logic        kick_pend_q, kick_pend_d;
    logic [3:0]  miss_q, miss_d;
    logic        rreq_q, rreq_d;
    logic        cs_q, cs_d;
    logic        wn_q, wn_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wd_q, wd_d;

    // start_q holds INIT_CTL for one extra edge so its write becomes visible after release.
    always_comb begin
        state_d     = state_q;
        kick_pend_d = kick_pend_q | kick_i;
        miss_d      = miss_q;
        case (state_q)
            INIT_CTL: state_d = start_q ? INIT_CTL : INIT_CLR;
            INIT_CLR: state_d = IDLE;
            IDLE: begin
                if (bus.irq)                    state_d = RD_STAT;
                else if (kick_pend_q || kick_i) state_d = KICK;
            end
            RD_STAT:  state_d = RD_WAIT;
            RD_WAIT:  state_d = bus.readdata[0] ? CLR_STAT : IDLE;
            CLR_STAT: begin
                miss_d  = (miss_q >= MAX_M) ? MAX_M : miss_q + 4'd1;
                state_d = IDLE;
            end
            KICK: begin
                kick_pend_d = kick_i;
                miss_d      = 4'd0;
                state_d     = IDLE;
            end
            default:  state_d = INIT_CTL;
        endcase

        rreq_d = rreq_q | (miss_d == MAX_M);

        // Bus outputs are registered from the state being entered.
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'h0000;
        case (state_d)
            INIT_CTL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0001; end
            INIT_CLR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            RD_STAT:  begin cs_d = 1'b1; wn_d = 1'b1; addr_d = 3'd0; end
            CLR_STAT: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            KICK:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_CTL;
            start_q     <= 1'b1;
            kick_pend_q <= 1'b0;
            miss_q      <= 4'd0;
            rreq_q      <= 1'b0;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= 3'd0;
            wd_q        <= 16'h0000;
        end else begin
            state_q     <= state_d;
            start_q     <= 1'b0;
            kick_pend_q <= kick_pend_d;
            miss_q      <= miss_d;
            rreq_q      <= rreq_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.chipselect = cs_q;
    assign bus.write_n    = wn_q;
    assign bus.address    = addr_q;
    assign bus.writedata  = wd_q;
    assign miss_count_o   = miss_q;
    assign reset_req_o    = rreq_q;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_wd_timer_servicer.sv
// Bench for wd_timer_servicer: directed cycle-exact scenarios plus a randomized event stream
// checked against an event-level model of miss counting and the sticky reset request.
module tb_wd_timer_servicer;
    localparam int MAXM = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kick = 1'b0;
    logic [3:0] miss;
    logic       rreq;
    logic       busy;
    logic [15:0] status_rd = 16'h0000;

    wd_timer_servicer_if bus();

    wd_timer_servicer #(.MAX_MISSES(MAXM)) dut (
        .clk          (clk),
        .reset        (reset),
        .kick_i       (kick),
        .bus          (bus),
        .miss_count_o (miss),
        .reset_req_o  (rreq),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Timer slave: registered readdata on a read strobe.
    initial bus.readdata = 16'h0000;
    always @(posedge clk) if (bus.chipselect && bus.write_n) bus.readdata <= status_rd;

    int n_kwr = 0, n_rd = 0, n_clr = 0;
    always @(negedge clk) begin
        if (bus.chipselect) begin
            if (!bus.write_n && bus.address == 3'd2)      n_kwr++;
            else if (bus.write_n && bus.address == 3'd0)  n_rd++;
            else if (!bus.write_n && bus.address == 3'd0) n_clr++;
        end
    end

    int n_cmp = 0, n_fail = 0;
    int exp_miss = 0;
    logic exp_rreq = 1'b0;

    function automatic logic [20:0] snap();
        return {bus.chipselect, bus.write_n, bus.address, bus.writedata};
    endfunction

    function automatic logic [20:0] acc(input logic cs, input logic wn,
                                        input logic [2:0] a, input logic [15:0] d);
        return {cs, wn, a, d};
    endfunction

    // {busy, bus snapshot, miss_count, reset_req}
    function automatic logic [26:0] obs();
        return {busy, snap(), miss, rreq};
    endfunction

    function automatic logic [26:0] want(input logic b, input logic [20:0] s);
        return {b, s, 4'(exp_miss), exp_rreq};
    endfunction

    task automatic cmp(input string nm, input logic [26:0] got, input logic [26:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        exp_miss = 0; exp_rreq = 1'b0;
        cmp("reset_hold", obs(), want(1'b1, acc(0, 1, 3'd0, 16'h0)));
        reset = 1'b0;
        @(negedge clk);
        cmp("init_ctl", obs(), want(1'b1, acc(1, 0, 3'd1, 16'h0001)));
        @(negedge clk);
        cmp("init_clr", obs(), want(1'b1, acc(1, 0, 3'd0, 16'h0000)));
        @(negedge clk);
        cmp("init_idle", obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
    endtask

    task automatic test_timeout(input logic [15:0] st, input string nm);
        status_rd = st;
        bus.irq = 1'b1;
        @(negedge clk);
        cmp({nm, "_rd_stat"}, obs(), want(1'b1, acc(1, 1, 3'd0, 16'h0)));
        @(negedge clk);
        cmp({nm, "_rd_wait"}, obs(), want(1'b1, acc(0, 1, 3'd0, 16'h0)));
        if (st[0]) begin
            @(negedge clk);
            cmp({nm, "_clr_stat"}, obs(), want(1'b1, acc(1, 0, 3'd0, 16'h0)));
            bus.irq = 1'b0;
            exp_miss = (exp_miss < MAXM) ? exp_miss + 1 : MAXM;
            if (exp_miss == MAXM) exp_rreq = 1'b1;
        end else begin
            bus.irq = 1'b0;
        end
        @(negedge clk);
        cmp({nm, "_idle"}, obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
    endtask

    task automatic test_kick(input string nm);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        cmp({nm, "_write"}, obs(), want(1'b1, acc(1, 0, 3'd2, 16'h0)));
        exp_miss = 0;
        @(negedge clk);
        cmp({nm, "_idle"}, obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) test_timeout(16'h0003, $sformatf("sat%0d", i));
        test_kick("sat_kick");
    endtask

    task automatic test_irq_kick();
        int base;
        base = n_kwr;
        status_rd = 16'h0003;
        bus.irq = 1'b1; kick = 1'b1;
        @(negedge clk); kick = 1'b0;
        cmp("ik_rd_stat", obs(), want(1'b1, acc(1, 1, 3'd0, 16'h0)));
        @(negedge clk); kick = 1'b1;
        cmp("ik_rd_wait", obs(), want(1'b1, acc(0, 1, 3'd0, 16'h0)));
        @(negedge clk); kick = 1'b0; bus.irq = 1'b0;
        cmp("ik_clr_stat", obs(), want(1'b1, acc(1, 0, 3'd0, 16'h0)));
        exp_miss = (exp_miss < MAXM) ? exp_miss + 1 : MAXM;
        if (exp_miss == MAXM) exp_rreq = 1'b1;
        @(negedge clk);
        cmp("ik_idle", obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
        @(negedge clk);
        cmp("ik_kick", obs(), want(1'b1, acc(1, 0, 3'd2, 16'h0)));
        exp_miss = 0;
        @(negedge clk);
        cmp("ik_idle2", obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_kwr - base != 1) begin
            n_fail++;
            $display("FAIL ik_kick_count: got %0d want 1", n_kwr - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = n_kwr;
        status_rd = 16'h0003;
        bus.irq = 1'b1; kick = 1'b1;
        @(negedge clk);
        cmp("rm_rd_stat", obs(), want(1'b1, acc(1, 1, 3'd0, 16'h0)));
        reset = 1'b1; kick = 1'b0; bus.irq = 1'b0;
        exp_miss = 0; exp_rreq = 1'b0;
        @(negedge clk);
        cmp("rm_in_reset", obs(), want(1'b1, acc(0, 1, 3'd0, 16'h0)));
        reset = 1'b0;
        @(negedge clk);
        cmp("rm_init_ctl", obs(), want(1'b1, acc(1, 0, 3'd1, 16'h0001)));
        @(negedge clk);
        cmp("rm_init_clr", obs(), want(1'b1, acc(1, 0, 3'd0, 16'h0000)));
        @(negedge clk);
        cmp("rm_idle", obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_kwr - base != 0) begin
            n_fail++;
            $display("FAIL rm_no_kick: got %0d kick writes want 0", n_kwr - base);
        end
    endtask

    // One event from IDLE; the slave drops irq once the relevant access is seen.
    task automatic drive_event(input logic do_irq, input logic real_to, input logic do_kick);
        status_rd = real_to ? 16'h0003 : 16'h0002;
        bus.irq = do_irq; kick = do_kick;
        @(negedge clk); kick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.chipselect && bus.address == 3'd0 && (bus.write_n ? !real_to : 1'b1))
                bus.irq = 1'b0;
            @(negedge clk);
        end
        bus.irq = 1'b0;
    endtask

    task automatic test_random();
        int ev, k0, r0, c0, ek, er, ec;
        for (int it = 0; it < 60; it++) begin
            ev = $urandom_range(0, 9);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (ev == 9) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                reset = 1'b0;
                exp_miss = 0; exp_rreq = 1'b0;
                repeat (4) @(negedge clk);
                cmp($sformatf("rnd%0d_reset", it), obs(), want(1'b0, acc(0, 1, 3'd0, 16'h0)));
            end else begin
                k0 = n_kwr; r0 = n_rd; c0 = n_clr;
                ek = 0; er = 0; ec = 0;
                if (ev >= 3) begin
                    er = 1;
                    if (ev != 6) begin
                        ec = 1;
                        exp_miss = (exp_miss < MAXM) ? exp_miss + 1 : MAXM;
                        if (exp_miss == MAXM) exp_rreq = 1'b1;
                    end
                end
                if (ev <= 2 || ev >= 7) begin
                    ek = 1;
                    exp_miss = 0;
                end
                drive_event(ev >= 3, ev != 6, ev <= 2 || ev >= 7);
                cmp($sformatf("rnd%0d_ev%0d_state", it, ev), obs(),
                    want(1'b0, acc(0, 1, 3'd0, 16'h0)));
                n_cmp++;
                if ({n_kwr - k0, n_rd - r0, n_clr - c0} !== {ek, er, ec}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_ev%0d_accesses: got k%0d r%0d c%0d want k%0d r%0d c%0d",
                             it, ev, n_kwr - k0, n_rd - r0, n_clr - c0, ek, er, ec);
                end
            end
        end
    endtask

    initial begin
        bus.irq = 1'b0;
        test_reset();
        test_timeout(16'h0003, "to1");
        test_timeout(16'h0002, "spur");
        test_timeout(16'h0003, "to2");
        test_kick("kick");
        test_saturate();
        test_irq_kick();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wd_timer_servicer.md
# wd_timer_servicer

Avalon-MM master that services the fixed-period watchdog interval timer slave (16-bit data, 3-bit word address, registered readdata, no waitrequest). On reset it enables the timer interrupt; afterwards it translates heartbeat pulses into timer reloads and services timeout interrupts. It counts consecutive missed heartbeats and raises a sticky board-reset request when the count reaches a limit. It sits beside the timer on the same bus segment, between the host heartbeat logic and the board reset controller.

## Interface
- MAX_MISSES, 3: consecutive serviced timeouts, with no kick in between, that assert reset_req (1..15).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- kick  in  1  heartbeat pulse; any cycle high is one kick request.
- irq  in  1  timer interrupt (level).
- address  out  3  timer word address.
- chipselect  out  1  bus access strobe; exactly one cycle per access.
- write_n  out  1  low = write, high = read.
- writedata  out  16  write data.
- readdata  in  16  timer read data; registered by the slave (valid the cycle after address is presented).
- miss_count  out  4  consecutive missed-heartbeat count, saturating at MAX_MISSES.
- reset_req  out  1  sticky reset request to the board reset controller.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Timer register map: 0 = status (bit0 timeout, bit1 running; any write clears timeout); 1 = control (bit0 irq enable); 2 = period_l (any write forces reload).
- States: INIT_CTL, INIT_CLR, IDLE, RD_STAT, RD_WAIT, CLR_STAT, KICK.
- INIT_CTL: write 0x0001 to address 1; next state INIT_CLR.
- INIT_CLR: write 0x0000 to address 0; next state IDLE.
- IDLE, priority order:
  - irq high -> RD_STAT.
  - else if kick_pend -> KICK.
  - else stay in IDLE.
- RD_STAT: read address 0 (chipselect=1, write_n=1). Next state RD_WAIT.
- RD_WAIT: no strobe; sample readdata.
  - bit0=1 -> CLR_STAT.
  - bit0=0 (spurious) -> IDLE; no count change.
- CLR_STAT: write 0x0000 to address 0. miss_count <= min(miss_count+1, MAX_MISSES). Next state IDLE.
- KICK: write 0x0000 to address 2. Clear kick_pend and miss_count. Next state IDLE.
- kick_pend:
  - Set by kick in any state, including the KICK cycle itself, where set wins over clear.
  - Depth is one; extra kicks while pending merge.
- reset_req is set when miss_count becomes MAX_MISSES. It is cleared only by reset; kicks do not clear it. The FSM keeps servicing after reset_req is set.
- Idle bus outputs: chipselect=0, write_n=1, address=0, writedata=0.

## Timing
- Reset values: state INIT_CTL, chipselect=0, write_n=1, address=0, writedata=0, miss_count=0, reset_req=0, busy=1, kick_pend=0.
- Outputs are registered and change on the clk edge that enters a state; the strobe is visible during the state's single cycle.
- Init sequence after reset release:
  - Cycle 0: INIT_CTL write.
  - Cycle 1: INIT_CLR write.
  - Cycle 2: IDLE, busy=0.
- Kick latency: kick high in IDLE cycle t -> KICK write in t+1 (kick_pend sampled in t+1 goes straight to KICK without an extra IDLE cycle) -> IDLE in t+2.
- Timeout service: irq high in IDLE at t -> RD_STAT at t+1 -> RD_WAIT at t+2 (readdata sampled) -> CLR_STAT at t+3 -> IDLE at t+4. The slave drops irq at t+4, so IDLE does not re-enter service.
- Simultaneous irq and kick in IDLE: service runs first, then KICK. The kick clears the miss just counted.
- Reset asserted mid-access: strobes drop on the next edge; the FSM restarts at INIT_CTL and the pending kick is lost.
- miss_count never exceeds MAX_MISSES and never wraps.

## Test plan
- Reset release -> addr1 write 0x0001, then addr0 write 0x0000, then busy=0 at cycle 2; miss_count=0, reset_req=0.
- Single kick pulse in IDLE -> one addr2 write exactly one cycle later; miss_count 2 -> 0.
- irq with status readdata=0x0003 -> addr0 read, then addr0 write 0x0000, 4 cycles total; miss_count +1.
- irq with readdata=0x0002 (spurious, irq held low by model afterwards) -> read only, no write, miss_count unchanged.
- Three timeouts with MAX_MISSES=3 and no kicks -> reset_req rises in the cycle after the third CLR_STAT. A subsequent kick gives miss_count=0 while reset_req stays 1.
- irq and kick in the same cycle, plus a second kick during RD_WAIT -> service sequence, then exactly one addr2 write. Then assert reset during RD_STAT -> INIT_CTL next, no KICK issued.
